cpu_control: RTL and testbench

CPU_CONTROL -- requirements
Module: cpu_control

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/cpu_instr_decode.sv | 75 +++++++
 rtl/cpu_control.sv | 132 +++++++++++++
 tb/tb_cpu_control.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the CPU control slice.
// Holds opcode constants, ALU operation codes (also used by the ALU), the
// control FSM state encoding, branch classes and instruction field positions.
package cpu_pkg;

    // Opcodes, instr[15:12]
    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4;
    localparam logic [3:0] OpLh   = 4'd5;
    localparam logic [3:0] OpLl   = 4'd6;
    localparam logic [3:0] OpBeq  = 4'd8;
    localparam logic [3:0] OpBgt  = 4'd9;
    localparam logic [3:0] OpBlt  = 4'd10;
    localparam logic [3:0] OpJmp  = 4'd11;
    localparam logic [3:0] OpHalt = 4'd15;

    // ALU operation codes
    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluAnd = 3'd2;
    localparam logic [2:0] AluOr  = 3'd3;
    localparam logic [2:0] AluXor = 3'd4;
    localparam logic [2:0] AluLh  = 3'd5;
    localparam logic [2:0] AluLl  = 3'd6;

    // Instruction field bit positions
    localparam int unsigned OpcMsb = 15;
    localparam int unsigned OpcLsb = 12;
    localparam int unsigned RdMsb  = 11;  // rd, or rs1 for LH/LL/branch/JMP
    localparam int unsigned RdLsb  = 9;
    localparam int unsigned Rs1Msb = 8;   // rs1, or rs2 for branches
    localparam int unsigned Rs1Lsb = 6;
    localparam int unsigned Rs2Msb = 5;
    localparam int unsigned Rs2Lsb = 3;
    localparam int unsigned ImmMsb = 7;
    localparam int unsigned ImmLsb = 0;
    localparam int unsigned OffMsb = 5;
    localparam int unsigned OffLsb = 0;

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        BrNone,
        BrEq,
        BrGt,
        BrLt,
        BrJmp
    } br_type_e;

endpackage

// File: rtl/cpu_instr_decode.sv
// cpu_instr_decode -- purely combinational instruction decoder.
// Ports:
//   instr      in   16  instruction word
//   rd_addr    out  3   destination register select
//   rs1_addr   out  3   first source register select
//   rs2_addr   out  3   second source register select
//   alu_op     out  3   ALU operation
//   alu_imm    out  8   ALU immediate byte (LH/LL only, else 0)
//   writes_rd  out  1   instruction writes the register file
//   br_type    out  -   branch/jump class
//   br_off     out  6   signed branch offset field
//   is_halt    out  1   HALT opcode
//   is_illegal out  1   unassigned opcode
module cpu_instr_decode
    import cpu_pkg::*;
(
    input  logic [15:0] instr,
    output logic [2:0]  rd_addr,
    output logic [2:0]  rs1_addr,
    output logic [2:0]  rs2_addr,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_imm,
    output logic        writes_rd,
    output br_type_e    br_type,
    output logic [5:0]  br_off,
    output logic        is_halt,
    output logic        is_illegal
);

    logic [3:0] opcode;
    assign opcode = instr[OpcMsb:OpcLsb];

    always_comb begin
        rd_addr    = '0;
        rs1_addr   = '0;
        rs2_addr   = '0;
        alu_op     = AluAdd;
        alu_imm    = '0;
        writes_rd  = 1'b0;
        br_type    = BrNone;
        br_off     = instr[OffMsb:OffLsb];
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
                rd_addr   = instr[RdMsb:RdLsb];
                rs1_addr  = instr[Rs1Msb:Rs1Lsb];
                rs2_addr  = instr[Rs2Msb:Rs2Lsb];
                alu_op    = opcode[2:0];
                writes_rd = 1'b1;
            end
            OpLh, OpLl: begin
                // Byte loads modify rd in place, so rd doubles as rs1
                rd_addr   = instr[RdMsb:RdLsb];
                rs1_addr  = instr[RdMsb:RdLsb];
                alu_imm   = instr[ImmMsb:ImmLsb];
                alu_op    = opcode[2:0];
                writes_rd = 1'b1;
            end
            OpBeq, OpBgt, OpBlt: begin
                rs1_addr = instr[RdMsb:RdLsb];
                rs2_addr = instr[Rs1Msb:Rs1Lsb];
                alu_op   = AluSub;
                br_type  = (opcode == OpBeq) ? BrEq : (opcode == OpBgt) ? BrGt : BrLt;
            end
            OpJmp: begin
                rs1_addr = instr[RdMsb:RdLsb];
                br_type  = BrJmp;
            end
            OpHalt:  is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// cpu_control -- FETCH/EXEC/HALT control unit with program counter.
// Build option: define CPU_CONTROL_ILLEGAL_TRAP_EN to trap illegal opcodes
// (sticky illegal flag + HALT); otherwise they execute as NOPs.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req/imem_addr             fetch request (level) and word address (= pc)
//   imem_ack/imem_data             fetch acknowledge and instruction word
//   rs1_addr/rs2_addr/rd_addr      register-file selects (0 outside EXEC)
//   rd_we                          register-file write strobe (EXEC only)
//   alu_op/alu_imm                 ALU operation and immediate (0 outside EXEC)
//   alu_eq/alu_gt/alu_lt           unsigned compare flags for branches
//   rs1_value                      rs1 read data, JMP target
//   pc, halted, illegal            status
module cpu_control
    import cpu_pkg::*;
#(
    parameter int unsigned REG_WIDTH   = 16,
    parameter int unsigned INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [REG_WIDTH-1:0]   imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [2:0]             rs1_addr,
    output logic [2:0]             rs2_addr,
    output logic [2:0]             rd_addr,
    output logic                   rd_we,
    output logic [2:0]             alu_op,
    output logic [7:0]             alu_imm,
    input  logic                   alu_eq,
    input  logic                   alu_gt,
    input  logic                   alu_lt,
    input  logic [REG_WIDTH-1:0]   rs1_value,
    output logic [REG_WIDTH-1:0]   pc,
    output logic                   halted,
    output logic                   illegal
);

    state_e                 state_q;
    logic [REG_WIDTH-1:0]   pc_q;
    logic [REG_WIDTH-1:0]   pc_next;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic                   illegal_q;
    logic                   exec;
    logic                   trap;

    logic [2:0] dec_rd, dec_rs1, dec_rs2, dec_op;
    logic [7:0] dec_imm;
    logic       dec_writes_rd, dec_halt, dec_illegal;
    logic [5:0] dec_off;
    br_type_e   dec_br;

    cpu_instr_decode u_decode (
        .instr      (ir_q),
        .rd_addr    (dec_rd),
        .rs1_addr   (dec_rs1),
        .rs2_addr   (dec_rs2),
        .alu_op     (dec_op),
        .alu_imm    (dec_imm),
        .writes_rd  (dec_writes_rd),
        .br_type    (dec_br),
        .br_off     (dec_off),
        .is_halt    (dec_halt),
        .is_illegal (dec_illegal)
    );

`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
    assign trap = dec_illegal;
`else
    // Illegal opcodes fall through as NOPs: no write, pc+1
    assign trap = 1'b0;
    logic unused_dec_illegal;
    assign unused_dec_illegal = dec_illegal;
`endif

    assign exec      = (state_q == StExec);
    assign imem_req  = (state_q == StFetch);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = (state_q == StHalt);
    assign illegal   = illegal_q;

    assign rd_addr  = exec ? dec_rd  : 3'd0;
    assign rs1_addr = exec ? dec_rs1 : 3'd0;
    assign rs2_addr = exec ? dec_rs2 : 3'd0;
    assign alu_op   = exec ? dec_op  : 3'd0;
    assign alu_imm  = exec ? dec_imm : 8'd0;
    assign rd_we    = exec & dec_writes_rd;

    // Branch offset is relative to the branch's own address; wraps mod 2^REG_WIDTH
    always_comb begin
        pc_next = pc_q + REG_WIDTH'(1);
        case (dec_br)
            BrEq:    if (alu_eq) pc_next = pc_q + {{(REG_WIDTH-6){dec_off[5]}}, dec_off};
            BrGt:    if (alu_gt) pc_next = pc_q + {{(REG_WIDTH-6){dec_off[5]}}, dec_off};
            BrLt:    if (alu_lt) pc_next = pc_q + {{(REG_WIDTH-6){dec_off[5]}}, dec_off};
            BrJmp:   pc_next = rs1_value;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            pc_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (imem_ack) begin
                        ir_q    <= imem_data;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (dec_halt || trap) begin
                        state_q <= StHalt;  // pc stays on the halting instruction
                    end else begin
                        pc_q    <= pc_next;
                        state_q <= StFetch;
                    end
                    if (trap) illegal_q <= 1'b1;
                end
                default: ;  // StHalt: only rst leaves
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [2:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_we;
    logic [2:0]  alu_op;
    logic [7:0]  alu_imm;
    logic        alu_eq, alu_gt, alu_lt;
    logic [15:0] rs1_value;
    logic [15:0] pc;
    logic        halted;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    cpu_control #(
        .REG_WIDTH   (16),
        .INSTR_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rd_addr   (rd_addr),
        .rd_we     (rd_we),
        .alu_op    (alu_op),
        .alu_imm   (alu_imm),
        .alu_eq    (alu_eq),
        .alu_gt    (alu_gt),
        .alu_lt    (alu_lt),
        .rs1_value (rs1_value),
        .pc        (pc),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one word with ack in FETCH; returns #1 after the edge that enters EXEC
    task automatic fetch_exec(input logic [15:0] word);
        imem_ack  = 1'b1;
        imem_data = word;
        step();
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_data = 16'h0000;
        alu_eq = 1'b0; alu_gt = 1'b0; alu_lt = 1'b0; rs1_value = 16'h0000;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst_req", imem_req, 1);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_rd_we", rd_we, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_alu_op", alu_op, 0);

        // ADD r1,r2,r3 at pc=0
        fetch_exec(16'h0298);
        chk("add_rd_we", rd_we, 1);
        chk("add_rd", rd_addr, 1);
        chk("add_rs1", rs1_addr, 2);
        chk("add_rs2", rs2_addr, 3);
        chk("add_op", alu_op, 0);
        chk("add_req_exec", imem_req, 0);
        step();
        chk("add_pc", pc, 16'h0001);
        chk("add_fetch_req", imem_req, 1);
        chk("add_fetch_we", rd_we, 0);

        // LH r5,0x7F at pc=1
        fetch_exec(16'h5A7F);
        chk("lh_rd", rd_addr, 5);
        chk("lh_rs1", rs1_addr, 5);
        chk("lh_imm", alu_imm, 8'h7F);
        chk("lh_op", alu_op, 5);
        chk("lh_we", rd_we, 1);
        step();
        chk("lh_pc", pc, 16'h0002);
        chk("lh_imm_idle", alu_imm, 0);

        // JMP r3 -> 5
        rs1_value = 16'h0005;
        fetch_exec(16'hB600);
        chk("jmp_rs1", rs1_addr, 3);
        chk("jmp_we", rd_we, 0);
        step();
        chk("jmp_pc", pc, 16'h0005);

        // BEQ r5,r0,-2 taken
        alu_eq = 1'b1;
        fetch_exec(16'h8A3E);
        chk("beq_rs1", rs1_addr, 5);
        chk("beq_rs2", rs2_addr, 0);
        chk("beq_op", alu_op, 1);
        chk("beq_we", rd_we, 0);
        step();
        chk("beq_taken_pc", pc, 16'h0003);

        // Back to 5, BEQ not taken
        fetch_exec(16'hB600);
        step();
        alu_eq = 1'b0;
        fetch_exec(16'h8A3E);
        step();
        chk("beq_not_taken_pc", pc, 16'h0006);

        // BGT +1 taken at pc=6
        alu_gt = 1'b1;
        fetch_exec(16'h9001);
        step();
        alu_gt = 1'b0;
        chk("bgt_pc", pc, 16'h0007);

        // Withheld ack at pc=7
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, 16'h0007);
            chk("wait_we", rd_we, 0);
        end
        // BLT -1 not taken
        alu_lt = 1'b0;
        fetch_exec(16'hA03F);
        chk("blt_in_exec", imem_req, 0);
        chk("blt_op", alu_op, 1);
        step();
        chk("blt_pc", pc, 16'h0008);

        // JMP to 0xFFFF, then ADD wraps pc to 0
        rs1_value = 16'hFFFF;
        fetch_exec(16'hB600);
        step();
        chk("jmp_ffff_addr", imem_addr, 16'hFFFF);
        fetch_exec(16'h0298);
        step();
        chk("wrap_addr", imem_addr, 16'h0000);

        // Illegal opcode at pc=2
        rs1_value = 16'h0002;
        fetch_exec(16'hB600);
        step();
        chk("jmp2_pc", pc, 16'h0002);
        fetch_exec(16'hD000);
        chk("ill_we", rd_we, 0);
        step();
`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
        chk("ill_flag", illegal, 1);
        chk("ill_halted", halted, 1);
        chk("ill_pc", pc, 16'h0002);
`else
        chk("ill_flag", illegal, 0);
        chk("ill_halted", halted, 0);
        chk("ill_pc", pc, 16'h0003);
        // HALT at pc=3
        fetch_exec(16'hF000);
        step();
        chk("halt_halted", halted, 1);
        chk("halt_pc", pc, 16'h0003);
`endif
        // HALT is terminal; ack ignored
        imem_ack = 1'b1; imem_data = 16'h0298;
        step(); step();
        chk("halt_stay", halted, 1);
        chk("halt_req", imem_req, 0);
        chk("halt_we", rd_we, 0);
`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
        chk("ill_sticky", illegal, 1);
`endif

        // rst with coincident ack exits HALT
        rst = 1'b1;
        step();
        rst = 1'b0; imem_ack = 1'b0;
        chk("hrst_pc", pc, 16'h0000);
        chk("hrst_halted", halted, 0);
        chk("hrst_req", imem_req, 1);
        chk("hrst_illegal", illegal, 0);
        step();
        chk("hrst_ack_discarded", imem_req, 1);
        chk("hrst_ack_we", rd_we, 0);

        // rst mid-fetch at pc=1 with ack high
        fetch_exec(16'h0298);
        step();
        chk("mf_pc1", pc, 16'h0001);
        step();
        rst = 1'b1; imem_ack = 1'b1; imem_data = 16'h0298;
        step();
        rst = 1'b0; imem_ack = 1'b0;
        chk("mf_pc", pc, 16'h0000);
        chk("mf_req", imem_req, 1);
        chk("mf_we", rd_we, 0);
        step();
        chk("mf_still_fetch", imem_req, 1);
        chk("mf_no_exec", rd_we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
